xosc_startup_ctrl: RTL and testbench

Sequences the crystal-oscillator pad. Drives the pad enable, waits a programmable stabilisation time, then checks that the pad clock output is toggling. Asserts ready/clock-select only after that check passes, and keeps monitoring for loss of clock. Runs on the always-on RC clock in the PMU domain; its outputs feed the oscillator pad enable and the system clock mux select.

---
 rtl/xosc_pkg.sv | 22 ++
 rtl/xosc_act_mon.sv | 72 +++++++
 rtl/xosc_startup_ctrl.sv | 168 ++++++++++++++++
 tb/tb_xosc_startup_ctrl.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/xosc_pkg.sv
// -----------------------------------------------------------------------------
// xosc_pkg
// Shared definitions for the crystal-oscillator startup controller.
//   xosc_state_e  : 3-bit FSM state encoding, also visible on xosc_state
//   RETRY_GAP_CYC : pad-off gap before a retry (used with XOSC_AUTO_RETRY_EN)
//   MAX_RETRY     : retries allowed before giving up (used with XOSC_AUTO_RETRY_EN)
// -----------------------------------------------------------------------------
package xosc_pkg;

    typedef enum logic [2:0] {
        ST_OFF   = 3'd0,
        ST_START = 3'd1,
        ST_CHECK = 3'd2,
        ST_READY = 3'd3,
        ST_FAIL  = 3'd4,
        ST_RETRY = 3'd5
    } xosc_state_e;

    localparam int unsigned RETRY_GAP_CYC = 16;
    localparam int unsigned MAX_RETRY     = 3;

endpackage

// File: rtl/xosc_act_mon.sv
// -----------------------------------------------------------------------------
// xosc_act_mon
// Activity monitor for the crystal pad clock. Synchronises xosc_clk into the
// RC clock domain, detects rising edges and counts them over back-to-back
// windows of WIN_CYC cycles.
// Ports:
//   clk       in   always-on RC clock
//   rst_b     in   synchronous active-low reset
//   xosc_clk  in   pad clock, asynchronous to clk
//   win_start in   restart the window; the next cycle is window cycle 0
//   win_done  out  current cycle is the last cycle of a window
//   alive     out  edges in this window, including this cycle, >= MIN_EDGES
//                  (meaningful while win_done is high)
// -----------------------------------------------------------------------------
module xosc_act_mon
    import xosc_pkg::*;
#(
    parameter int unsigned WIN_CYC   = 64,
    parameter int unsigned MIN_EDGES = 8,
    parameter int unsigned CNT_W     = 16,
    parameter int unsigned EDGE_W    = 8
) (
    input  logic clk,
    input  logic rst_b,
    input  logic xosc_clk,
    input  logic win_start,
    output logic win_done,
    output logic alive
);

    localparam logic [CNT_W-1:0]  WIN_LAST = CNT_W'(WIN_CYC - 1);
    localparam logic [EDGE_W:0]   MIN_E    = (EDGE_W + 1)'(MIN_EDGES);
    localparam logic [EDGE_W-1:0] EDGE_MAX = '1;

    logic              sync1_q, sync2_q, sync3_q;
    logic [CNT_W-1:0]  win_cnt_q;
    logic [EDGE_W-1:0] edge_cnt_q;
    logic              rise;
    logic [EDGE_W:0]   edge_sum;

    assign rise     = sync2_q & ~sync3_q;
    assign win_done = (win_cnt_q == WIN_LAST);
    // One bit wider so a saturated count plus this cycle's edge cannot wrap.
    assign edge_sum = {1'b0, edge_cnt_q} + {{EDGE_W{1'b0}}, rise};
    assign alive    = (edge_sum >= MIN_E);

    // NOTE: sequential state is written with non-blocking assignments only.
    always_ff @(posedge clk) begin
        if (!rst_b) begin
            sync1_q    <= 1'b0;
            sync2_q    <= 1'b0;
            sync3_q    <= 1'b0;
            win_cnt_q  <= '0;
            edge_cnt_q <= '0;
        end else begin
            sync1_q <= xosc_clk;
            sync2_q <= sync1_q;
            sync3_q <= sync2_q;
            // Windows free-run back to back; win_start realigns them to the FSM.
            if (win_start || win_done) begin
                win_cnt_q  <= '0;
                edge_cnt_q <= '0;
            end else begin
                win_cnt_q <= win_cnt_q + CNT_W'(1);
                if (rise && (edge_cnt_q != EDGE_MAX)) begin
                    edge_cnt_q <= edge_cnt_q + EDGE_W'(1);
                end
            end
        end
    end

endmodule

// File: rtl/xosc_startup_ctrl.sv
// -----------------------------------------------------------------------------
// xosc_startup_ctrl
// Crystal-oscillator startup sequencer. Enables the pad, waits STARTUP_CYC
// cycles, verifies the pad clock toggles, then grants ready/clock-select and
// keeps monitoring for loss of clock.
// Optional feature macro: XOSC_AUTO_RETRY_EN (retry a failed check up to
// MAX_RETRY times with an RETRY_GAP_CYC pad-off gap before each retry).
// Ports:
//   clk          in   always-on RC clock
//   rst_b        in   synchronous active-low reset
//   xosc_en_req  in   level request to run the oscillator
//   xosc_clk     in   pad clock, asynchronous to clk
//   pad_xosc_en  out  pad enable
//   xosc_ready   out  oscillator verified running
//   xosc_clk_sel out  system clock mux selects the crystal
//   xosc_fail    out  sticky failure, cleared by dropping xosc_en_req
//   xosc_state   out  current FSM state
// -----------------------------------------------------------------------------
module xosc_startup_ctrl
    import xosc_pkg::*;
#(
    parameter int unsigned STARTUP_CYC = 1024,
    parameter int unsigned WIN_CYC     = 64,
    parameter int unsigned MIN_EDGES   = 8,
    parameter int unsigned CNT_W       = 16,
    parameter int unsigned EDGE_W      = 8
) (
    input  logic       clk,
    input  logic       rst_b,
    input  logic       xosc_en_req,
    input  logic       xosc_clk,
    output logic       pad_xosc_en,
    output logic       xosc_ready,
    output logic       xosc_clk_sel,
    output logic       xosc_fail,
    output logic [2:0] xosc_state
);

    localparam logic [CNT_W-1:0] START_LAST = CNT_W'(STARTUP_CYC - 1);

    xosc_state_e      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             win_start, win_done, alive;
    logic             pad_en_q, ready_q, sel_q, fail_q;

`ifdef XOSC_AUTO_RETRY_EN
    localparam logic [CNT_W-1:0] GAP_LAST    = CNT_W'(RETRY_GAP_CYC - 1);
    localparam logic [1:0]       RETRY_LIMIT = 2'(MAX_RETRY);
    logic [1:0] retry_q, retry_d;
`endif

    xosc_act_mon #(
        .WIN_CYC   (WIN_CYC),
        .MIN_EDGES (MIN_EDGES),
        .CNT_W     (CNT_W),
        .EDGE_W    (EDGE_W)
    ) u_act_mon (
        .clk       (clk),
        .rst_b     (rst_b),
        .xosc_clk  (xosc_clk),
        .win_start (win_start),
        .win_done  (win_done),
        .alive     (alive)
    );

    // NOTE: every signal gets a default first so no path infers a latch.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        win_start = 1'b0;
`ifdef XOSC_AUTO_RETRY_EN
        retry_d   = retry_q;
`endif
        // Withdrawing the request wins over any window verdict this cycle.
        if (!xosc_en_req) begin
            state_d = ST_OFF;
            cnt_d   = '0;
`ifdef XOSC_AUTO_RETRY_EN
            retry_d = '0;
`endif
        end else begin
            unique case (state_q)
                ST_OFF: begin
                    state_d = ST_START;
                    cnt_d   = '0;
                end
                ST_START: begin
                    if (cnt_q == START_LAST) begin
                        state_d   = ST_CHECK;
                        cnt_d     = '0;
                        win_start = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                ST_CHECK, ST_READY: begin
                    if (win_done) begin
                        if (alive) begin
                            state_d = ST_READY;
`ifdef XOSC_AUTO_RETRY_EN
                            retry_d = '0;
`endif
                        end else begin
`ifdef XOSC_AUTO_RETRY_EN
                            if (retry_q < RETRY_LIMIT) begin
                                state_d = ST_RETRY;
                                cnt_d   = '0;
                                retry_d = retry_q + 2'd1;
                            end else begin
                                state_d = ST_FAIL;
                            end
`else
                            state_d = ST_FAIL;
`endif
                        end
                    end
                end
                ST_FAIL: state_d = ST_FAIL;
`ifdef XOSC_AUTO_RETRY_EN
                ST_RETRY: begin
                    if (cnt_q == GAP_LAST) begin
                        state_d = ST_START;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
`endif
                default: begin
                    state_d = ST_OFF;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    // Outputs are decoded from the next state so they line up with the state register.
    always_ff @(posedge clk) begin
        if (!rst_b) begin
            state_q  <= ST_OFF;
            cnt_q    <= '0;
            pad_en_q <= 1'b0;
            ready_q  <= 1'b0;
            sel_q    <= 1'b0;
            fail_q   <= 1'b0;
`ifdef XOSC_AUTO_RETRY_EN
            retry_q  <= '0;
`endif
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            pad_en_q <= (state_d == ST_START) || (state_d == ST_CHECK) || (state_d == ST_READY);
            ready_q  <= (state_d == ST_READY);
            sel_q    <= (state_d == ST_READY);
            fail_q   <= (state_d == ST_FAIL);
`ifdef XOSC_AUTO_RETRY_EN
            retry_q  <= retry_d;
`endif
        end
    end

    assign pad_xosc_en  = pad_en_q;
    assign xosc_ready   = ready_q;
    assign xosc_clk_sel = sel_q;
    assign xosc_fail    = fail_q;
    assign xosc_state   = state_q;

endmodule

// File: tb/tb_xosc_startup_ctrl.sv
// -----------------------------------------------------------------------------
// tb_xosc_startup_ctrl
// Directed bench for xosc_startup_ctrl (default build, retry feature off).
// Inputs change and outputs are sampled on the falling edge of clk.
// Output bus order: {pad_xosc_en, xosc_ready, xosc_clk_sel, xosc_fail, xosc_state}.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_xosc_startup_ctrl;

    localparam logic [6:0] OFF_O   = 7'b0000_000;
    localparam logic [6:0] START_O = 7'b1000_001;
    localparam logic [6:0] CHECK_O = 7'b1000_010;
    localparam logic [6:0] READY_O = 7'b1110_011;
    localparam logic [6:0] FAIL_O  = 7'b0001_100;

    logic       clk = 1'b0;
    logic       rst_b = 1'b0;
    logic       xosc_en_req = 1'b0;
    logic       osc_free = 1'b0;
    logic       osc_man = 1'b0;
    logic       osc_run = 1'b0;
    logic       xosc_clk;
    logic       pad_xosc_en, xosc_ready, xosc_clk_sel, xosc_fail;
    logic [2:0] xosc_state;
    int         checks = 0;
    int         errors = 0;
    int         cyc;

    assign xosc_clk = osc_run ? osc_free : osc_man;

    xosc_startup_ctrl #(
        .STARTUP_CYC (32),
        .WIN_CYC     (16),
        .MIN_EDGES   (4),
        .CNT_W       (16),
        .EDGE_W      (8)
    ) dut (
        .clk          (clk),
        .rst_b        (rst_b),
        .xosc_en_req  (xosc_en_req),
        .xosc_clk     (xosc_clk),
        .pad_xosc_en  (pad_xosc_en),
        .xosc_ready   (xosc_ready),
        .xosc_clk_sel (xosc_clk_sel),
        .xosc_fail    (xosc_fail),
        .xosc_state   (xosc_state)
    );

    always #5 clk = ~clk;

    // Free-running pad clock at clk/3, offset so it never toggles on a clk edge.
    initial begin
        #3;
        forever #15 osc_free = ~osc_free;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [6:0] obs, input logic [6:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    function automatic logic [6:0] outs();
        return {pad_xosc_en, xosc_ready, xosc_clk_sel, xosc_fail, xosc_state};
    endfunction

    task automatic go_off();
        xosc_en_req = 1'b0;
        osc_run     = 1'b0;
        osc_man     = 1'b0;
        step(4);
    endtask

    // Request, then exactly n one-cycle pulses well inside the CHECK window.
    task automatic marginal(input int n, input string tag, input logic [6:0] exp);
        xosc_en_req = 1'b1;
        step(34);
        for (int i = 0; i < n; i++) begin
            osc_man = 1'b1;
            step(1);
            osc_man = 1'b0;
            step(2);
        end
        step(15 - 3 * n);
        check(tag, outs(), exp);
        go_off();
    endtask

    initial begin
        // Reset
        step(2);
        check("reset", outs(), OFF_O);
        rst_b = 1'b1;
        step(2);
        check("idle_no_req", outs(), OFF_O);

        // Nominal start with a live clk/3 crystal
        osc_run = 1'b1;
        xosc_en_req = 1'b1;
        step(1);
        check("nom_pad_on", outs(), START_O);
        step(47);
        check("nom_check_at_48", outs(), CHECK_O);
        step(1);
        check("nom_ready_at_49", outs(), READY_O);
        step(20);
        check("nom_ready_held", outs(), READY_O);
        go_off();

        // Dead crystal
        xosc_en_req = 1'b1;
        step(48);
        check("dead_check_at_48", outs(), CHECK_O);
        step(1);
        check("dead_fail_at_49", outs(), FAIL_O);
        step(5);
        check("dead_fail_held", outs(), FAIL_O);
        xosc_en_req = 1'b0;
        step(1);
        check("dead_req_drop", outs(), OFF_O);
        go_off();

        // Marginal edge counts
        marginal(4, "marginal_4_edges", READY_O);
        marginal(3, "marginal_3_edges", FAIL_O);

        // Request withdrawn mid-START
        xosc_en_req = 1'b1;
        step(11);
        check("mid_start_cnt10", outs(), START_O);
        xosc_en_req = 1'b0;
        step(1);
        check("mid_start_withdraw", outs(), OFF_O);
        go_off();

        // Reset pulsed in READY, then restart
        osc_run = 1'b1;
        xosc_en_req = 1'b1;
        step(49);
        check("rst_pre_ready", outs(), READY_O);
        rst_b = 1'b0;
        step(1);
        check("rst_in_ready", outs(), OFF_O);
        rst_b = 1'b1;
        step(1);
        check("rst_restart", outs(), START_O);
        step(48);
        check("loss_pre_ready", outs(), READY_O);

        // Loss of clock from READY
        osc_run = 1'b0;
        osc_man = 1'b0;
        cyc = 0;
        while (xosc_ready && cyc < 40) begin
            step(1);
            cyc++;
        end
        check("loss_within_32", {6'd0, (cyc <= 32) && !xosc_ready}, 7'd1);
        check("loss_fail_state", outs(), FAIL_O);
        go_off();
        check("final_off", outs(), OFF_O);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
